// File: rtl/tdm_pkg.sv
// Constants and types shared by the TDM link transmit sequencer and this receive demux.
package tdm_pkg;

  localparam int NUM_SLOTS = 8;
  localparam int SLOT_W    = 3;

  localparam logic [SLOT_W-1:0] FIRST_SLOT = 3'd0;
  localparam logic [SLOT_W-1:0] LAST_SLOT  = 3'd7;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  // The slot counter wraps naturally from LAST_SLOT back to FIRST_SLOT.
  function automatic logic [SLOT_W-1:0] slot_next(input logic [SLOT_W-1:0] cur);
    return cur + 3'd1;
  endfunction

endpackage

// File: rtl/tdm_demux_8ch_if.sv
// Link-side sample stream and frame-side channel outputs of the 8-slot TDM demux.
interface tdm_demux_8ch_if #(
  parameter int DATA_W = 1
) ();
  import tdm_pkg::*;

  logic [DATA_W-1:0]           din;
  logic                        din_valid;
  logic                        sync;
  logic [NUM_SLOTS*DATA_W-1:0] ch_out;
  logic                        frame_valid;
  logic                        locked;
  logic [SLOT_W-1:0]           slot;
  logic                        sync_err;

  modport master (
    output din, din_valid, sync,
    input  ch_out, frame_valid, locked, slot, sync_err
  );

  modport slave (
    input  din, din_valid, sync,
    output ch_out, frame_valid, locked, slot, sync_err
  );

endinterface

// File: rtl/tdm_demux_8ch_dec_3to8.sv
// Slot index to one-hot write enable; all-zero when the beat is not being written.
module dec_3to8
  import tdm_pkg::*;
(
  input  logic [SLOT_W-1:0]    idx,
  input  logic                 en,
  output logic [NUM_SLOTS-1:0] onehot
);

  // One-hot decode of the write slot
  always_comb begin
    onehot = 8'b0;
    if (en) begin
      onehot[idx] = 1'b1;
    end else begin
      onehot = 8'b0;
    end
  end

endmodule

// File: rtl/tdm_demux_8ch.sv
// Receive end of the 8-slot TDM link: locks to the slot-0 sync marker, collects one
// sample per slot and publishes each complete frame atomically with a one-cycle strobe.
module tdm_demux_8ch
  import tdm_pkg::*;
#(
  parameter int DATA_W       = 1,
  parameter bit REQUIRE_SYNC = 1'b1
) (
  input logic            clk,
  input logic            rst_n,
  tdm_demux_8ch_if.slave bus
);

  tdm_state_e                          state_q, state_d;
  logic [SLOT_W-1:0]                   slot_q, slot_d;
  logic [NUM_SLOTS-2:0][DATA_W-1:0]    shadow_q, shadow_d;
  logic [NUM_SLOTS*DATA_W-1:0]         ch_out_q, ch_out_d;
  logic                                frame_valid_q, frame_valid_d;
  logic                                sync_err_q, sync_err_d;
  logic                                locked_q, locked_d;

  logic                                wr_en_s;
  logic [SLOT_W-1:0]                   wr_idx_s;
  logic [NUM_SLOTS-1:0]                we_s;

  // Framing FSM: decides which slot (if any) the current beat lands in
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    sync_err_d = 1'b0;
    wr_en_s    = 1'b0;
    wr_idx_s   = FIRST_SLOT;
    case (state_q)
      HUNT: begin
        if (bus.din_valid && bus.sync) begin
          wr_en_s = 1'b1;
          slot_d  = slot_next(FIRST_SLOT);
          state_d = LOCKED;
        end else begin
          state_d = HUNT;
        end
      end
      LOCKED: begin
        if (!bus.din_valid) begin
          state_d = LOCKED;
        end else if (bus.sync) begin
          // An early sync restarts the frame at this beat; the slot-0 shadow is overwritten.
          sync_err_d = (slot_q != FIRST_SLOT);
          wr_en_s    = 1'b1;
          slot_d     = slot_next(FIRST_SLOT);
        end else if ((slot_q == FIRST_SLOT) && REQUIRE_SYNC) begin
          sync_err_d = 1'b1;
          slot_d     = FIRST_SLOT;
          state_d    = HUNT;
        end else begin
          wr_en_s  = 1'b1;
          wr_idx_s = slot_q;
          slot_d   = slot_next(slot_q);
        end
      end
      default: begin
        state_d = HUNT;
        slot_d  = FIRST_SLOT;
      end
    endcase
    locked_d = (state_d == LOCKED);
  end

  dec_3to8 u_dec (
    .idx    (wr_idx_s),
    .en     (wr_en_s),
    .onehot (we_s)
  );

  // Shadow bank fill; the slot-7 beat bypasses the bank straight into the output frame
  always_comb begin
    shadow_d = shadow_q;
    for (int k = 0; k < NUM_SLOTS - 1; k++) begin
      if (we_s[k]) begin
        shadow_d[k] = bus.din;
      end else begin
        shadow_d[k] = shadow_q[k];
      end
    end
    if (we_s[NUM_SLOTS-1]) begin
      ch_out_d      = {bus.din, shadow_q};
      frame_valid_d = 1'b1;
    end else begin
      ch_out_d      = ch_out_q;
      frame_valid_d = 1'b0;
    end
  end

  // State, shadow and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      slot_q        <= FIRST_SLOT;
      shadow_q      <= '0;
      ch_out_q      <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      slot_q        <= slot_d;
      shadow_q      <= shadow_d;
      ch_out_q      <= ch_out_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= locked_d;
    end
  end

  assign bus.ch_out      = ch_out_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.sync_err    = sync_err_q;
  assign bus.locked      = locked_q;
  assign bus.slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Directed bench for tdm_demux_8ch: one instance requiring sync on every frame (a),
// one free-running after lock (b), both fed the same beat stream.
module tb_tdm_demux_8ch;
  import tdm_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   fv_a;
  int   fv_b;
  int   both_hi;

  tdm_demux_8ch_if #(.DATA_W(1)) bus_a ();
  tdm_demux_8ch_if #(.DATA_W(1)) bus_b ();

  tdm_demux_8ch #(.DATA_W(1), .REQUIRE_SYNC(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  tdm_demux_8ch #(.DATA_W(1), .REQUIRE_SYNC(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe counters, sampled away from the active edge
  always @(negedge clk) begin
    if (bus_a.frame_valid) fv_a++;
    if (bus_b.frame_valid) fv_b++;
    if (bus_a.frame_valid && bus_a.sync_err) both_hi++;
    if (bus_b.frame_valid && bus_b.sync_err) both_hi++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic d, input logic s);
    bus_a.din_valid = v; bus_a.din = d; bus_a.sync = s;
    bus_b.din_valid = v; bus_b.din = d; bus_b.sync = s;
  endtask

  // One valid beat; returns 1 time unit after the capturing edge
  task automatic beat(input logic d, input logic s);
    @(negedge clk);
    drive(1'b1, d, s);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  // Idle cycles with sync and din toggled high to show they are ignored without din_valid
  task automatic gap(input int n);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1);
    repeat (n) @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] v);
    for (int k = 0; k < 8; k++) beat(v[k], (k == 0));
  endtask

  initial begin
    logic [7:0] v;
    int         fv0;
    checks = 0; failures = 0; fv_a = 0; fv_b = 0; both_hi = 0;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ch_out", {24'd0, bus_a.ch_out}, 32'h00);
    check("rst_locked", {31'd0, bus_a.locked}, 32'd0);
    check("rst_slot", {29'd0, bus_a.slot}, 32'd0);
    check("rst_fv", {31'd0, bus_a.frame_valid}, 32'd0);
    check("rst_err", {31'd0, bus_a.sync_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Beats before any sync are dropped
    for (int k = 0; k < 5; k++) beat(1'b1, 1'b0);
    check("hunt_ch_out", {24'd0, bus_a.ch_out}, 32'h00);
    check("hunt_locked", {31'd0, bus_a.locked}, 32'd0);
    check("hunt_slot", {29'd0, bus_a.slot}, 32'd0);
    check("hunt_b_locked", {31'd0, bus_b.locked}, 32'd0);

    // Back-to-back frame 1,0,1,1,0,0,1,0
    v = 8'h4D;
    beat(v[0], 1'b1);
    check("t1_lock", {31'd0, bus_a.locked}, 32'd1);
    check("t1_slot1", {29'd0, bus_a.slot}, 32'd1);
    for (int k = 1; k < 7; k++) beat(v[k], 1'b0);
    check("t1_hold_ch_out", {24'd0, bus_a.ch_out}, 32'h00);
    check("t1_fv_before", {31'd0, bus_a.frame_valid}, 32'd0);
    beat(v[7], 1'b0);
    check("t1_ch_out", {24'd0, bus_a.ch_out}, 32'h4D);
    check("t1_fv", {31'd0, bus_a.frame_valid}, 32'd1);
    check("t1_locked", {31'd0, bus_a.locked}, 32'd1);
    check("t1_slot0", {29'd0, bus_a.slot}, 32'd0);
    @(posedge clk);
    #1;
    check("t1_fv_pulse", {31'd0, bus_a.frame_valid}, 32'd0);

    // Same frame with 3-cycle gaps between beats
    fv0 = fv_a;
    for (int k = 0; k < 8; k++) begin
      beat(v[k], (k == 0));
      if (k < 7) begin
        gap(3);
        check($sformatf("t2_gap_slot%0d", k), {29'd0, bus_a.slot}, k + 1);
      end
    end
    check("t2_ch_out", {24'd0, bus_a.ch_out}, 32'h4D);
    gap(2);
    check("t2_fv_count", fv_a - fv0, 32'd1);
    check("t2_slot", {29'd0, bus_a.slot}, 32'd0);

    // Early sync on slot 4 restarts the frame at that beat
    for (int k = 0; k < 4; k++) beat(1'b1, (k == 0));
    check("t4_slot4", {29'd0, bus_a.slot}, 32'd4);
    v = 8'hA6;
    beat(v[0], 1'b1);
    check("t4_err", {31'd0, bus_a.sync_err}, 32'd1);
    check("t4_no_fv", {31'd0, bus_a.frame_valid}, 32'd0);
    check("t4_ch_out", {24'd0, bus_a.ch_out}, 32'h4D);
    check("t4_slot1", {29'd0, bus_a.slot}, 32'd1);
    check("t4_locked", {31'd0, bus_a.locked}, 32'd1);
    @(posedge clk);
    #1;
    check("t4_err_pulse", {31'd0, bus_a.sync_err}, 32'd0);
    for (int k = 1; k < 8; k++) beat(v[k], 1'b0);
    check("t4_new_ch_out", {24'd0, bus_a.ch_out}, 32'hA6);
    check("t4_new_fv", {31'd0, bus_a.frame_valid}, 32'd1);

    // Slot-0 beat without sync: error in (a), accepted in (b)
    v = 8'h55;
    beat(v[0], 1'b0);
    check("t5a_err", {31'd0, bus_a.sync_err}, 32'd1);
    check("t5a_locked", {31'd0, bus_a.locked}, 32'd0);
    check("t5a_slot", {29'd0, bus_a.slot}, 32'd0);
    check("t5b_err", {31'd0, bus_b.sync_err}, 32'd0);
    check("t5b_locked", {31'd0, bus_b.locked}, 32'd1);
    check("t5b_slot", {29'd0, bus_b.slot}, 32'd1);
    for (int k = 1; k < 8; k++) beat(v[k], 1'b0);
    check("t5b_ch_out", {24'd0, bus_b.ch_out}, 32'h55);
    check("t5b_fv", {31'd0, bus_b.frame_valid}, 32'd1);
    check("t5a_ch_out", {24'd0, bus_a.ch_out}, 32'hA6);
    check("t5a_no_fv", {31'd0, bus_a.frame_valid}, 32'd0);
    check("t5a_hunt", {31'd0, bus_a.locked}, 32'd0);

    // Asynchronous reset in the middle of a frame
    for (int k = 0; k < 5; k++) beat(1'b1, (k == 0));
    check("t6_slot5", {29'd0, bus_a.slot}, 32'd5);
    check("t6_locked", {31'd0, bus_a.locked}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_ch_out", {24'd0, bus_a.ch_out}, 32'h00);
    check("t6_rst_b_ch_out", {24'd0, bus_b.ch_out}, 32'h00);
    check("t6_rst_locked", {31'd0, bus_a.locked}, 32'd0);
    check("t6_rst_slot", {29'd0, bus_a.slot}, 32'd0);
    check("t6_rst_fv", {31'd0, bus_a.frame_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'hF0);
    check("t6_ch_out", {24'd0, bus_a.ch_out}, 32'hF0);
    check("t6_fv", {31'd0, bus_a.frame_valid}, 32'd1);
    check("t6_relock", {31'd0, bus_a.locked}, 32'd1);
    check("t6_b_ch_out", {24'd0, bus_b.ch_out}, 32'hF0);

    gap(2);
    check("fv_and_err_exclusive", both_hi, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
